rp_8bit_uart: RTL and testbench



---
 rtl/rp_8bit_uart.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_rp_8bit_uart.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rp_8bit_uart.sv
// UART slave for the rp_8bit I/O bus: TX FIFO + shift FSM, RX synchronizer + mid-bit sampler.
// Optional even parity (UCR[4] PEN) is built only when RP_8BIT_UART_PARITY_EN is defined.
module rp_8bit_uart #(
  parameter logic [5:0] ADR = 6'h0C,
  parameter int         FAW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic [1:0] irq_req,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int FDEPTH = 2 ** FAW;
`ifdef RP_8BIT_UART_PARITY_EN
  localparam logic [7:0] UCR_MASK = 8'h1F;
`else
  localparam logic [7:0] UCR_MASK = 8'h0F;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Bus decode
  logic [5:0] w_off;
  logic       w_hit;
  logic [7:0] w_wmask;
  logic       w_wr_udr, w_wr_usr, w_wr_ucr, w_wr_ubr, w_rd_udr;

  assign w_off    = io_adr - ADR;
  assign w_hit    = (w_off[5:2] == 4'd0);
  assign w_wmask  = io_wdt & io_msk;
  assign w_wr_udr = io_wen && w_hit && (w_off[1:0] == 2'd0);
  assign w_wr_usr = io_wen && w_hit && (w_off[1:0] == 2'd1);
  assign w_wr_ucr = io_wen && w_hit && (w_off[1:0] == 2'd2);
  assign w_wr_ubr = io_wen && w_hit && (w_off[1:0] == 2'd3);
  assign w_rd_udr = io_ren && w_hit && (w_off[1:0] == 2'd0);

  logic [7:0] r_ucr, r_ubr, r_rdr, r_rdt;
  logic       r_rxc, r_rov, r_fer, r_per;
  logic [1:0] r_irq;
  logic       w_txen, w_rxen, w_rxcie, w_txeie, w_pen;

  assign w_txen  = r_ucr[0];
  assign w_rxen  = r_ucr[1];
  assign w_rxcie = r_ucr[2];
  assign w_txeie = r_ucr[3];
`ifdef RP_8BIT_UART_PARITY_EN
  assign w_pen   = r_ucr[4];
`else
  assign w_pen   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ucr <= 8'h00;
      r_ubr <= 8'h00;
    end else begin
      if (w_wr_ucr) r_ucr <= (w_wmask | (r_ucr & ~io_msk)) & UCR_MASK;
      if (w_wr_ubr) r_ubr <= w_wmask | (r_ubr & ~io_msk);
    end
  end

  // TX FIFO; an extra pointer bit separates full from empty
  logic [7:0]   r_fifo [FDEPTH];
  logic [FAW:0] r_wptr, r_rptr;
  logic         w_empty, w_full, w_push, w_tx_pop;
  logic [7:0]   w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FAW] != r_rptr[FAW]) && (r_wptr[FAW-1:0] == r_rptr[FAW-1:0]);
  assign w_push  = w_wr_udr && (!w_full || w_tx_pop);
  assign w_head  = r_fifo[r_rptr[FAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FDEPTH; i++) r_fifo[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr[FAW-1:0]] <= w_wmask;
        r_wptr <= r_wptr + (FAW+1)'(1);
      end
      if (w_tx_pop) r_rptr <= r_rptr + (FAW+1)'(1);
    end
  end

  // TX FSM
  state_t     r_tx_state, w_tx_next;
  logic [7:0] r_tx_cnt, r_tx_div, r_tx_sr;
  logic [2:0] r_tx_bit;
  logic       r_tx_par, r_txd, w_txd, w_tx_tick, w_txe;

  assign w_tx_tick = (r_tx_cnt == r_tx_div);
  assign w_tx_pop  = w_txen && !w_empty &&
                     ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_tick));
  assign w_txe     = w_empty && (r_tx_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:  if (w_tx_pop) w_tx_next = S_START;
      S_START: if (w_tx_tick) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = w_pen ? S_PAR : S_STOP;
      S_PAR:   if (w_tx_tick) w_tx_next = S_STOP;
      S_STOP:  if (w_tx_tick) w_tx_next = w_tx_pop ? S_START : S_IDLE;
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd = 1'b1;
    case (r_tx_state)
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = r_tx_sr[0];
      S_PAR:   w_txd = r_tx_par;
      default: w_txd = 1'b1;
    endcase
  end

  // Divisor is relatched every bit so UBR edits land on a bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd    <= 1'b1;
      r_tx_cnt <= 8'h00;
      r_tx_div <= 8'h00;
      r_tx_sr  <= 8'h00;
      r_tx_bit <= 3'd0;
      r_tx_par <= 1'b0;
    end else begin
      r_txd <= w_txd;
      if (w_tx_pop) begin
        r_tx_sr  <= w_head;
        r_tx_par <= ^w_head;
        r_tx_bit <= 3'd0;
      end else if ((r_tx_state == S_DATA) && w_tx_tick) begin
        r_tx_sr  <= r_tx_sr >> 1;
        r_tx_bit <= r_tx_bit + 3'd1;
      end
      if ((r_tx_state == S_IDLE) || w_tx_tick) begin
        r_tx_cnt <= 8'h00;
        r_tx_div <= r_ubr;
      end else begin
        r_tx_cnt <= r_tx_cnt + 8'd1;
      end
    end
  end

  // RX FSM
  state_t     r_rx_state, w_rx_next;
  logic       r_rx_s1, r_rx_s2, w_rxd;
  logic [7:0] r_rx_cnt, r_rx_div, r_rx_sr, w_rx_half;
  logic [2:0] r_rx_bit;
  logic       r_rx_pbad, w_rx_tick, w_rx_deliver, w_rx_ferr, w_rx_pchk;

  assign w_rxd     = r_rx_s2;
  assign w_rx_half = r_rx_div >> 1;
  assign w_rx_tick = (r_rx_state == S_START) ? (r_rx_cnt == w_rx_half) : (r_rx_cnt == r_rx_div);

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    if (!w_rxen) begin
      w_rx_next = S_IDLE;
    end else begin
      case (r_rx_state)
        S_IDLE:  if (!w_rxd) w_rx_next = S_START;
        S_START: if (w_rx_tick) w_rx_next = w_rxd ? S_IDLE : S_DATA;
        S_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = w_pen ? S_PAR : S_STOP;
        S_PAR:   if (w_rx_tick) w_rx_next = S_STOP;
        S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
        default: w_rx_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rx_deliver = 1'b0;
    w_rx_ferr    = 1'b0;
    w_rx_pchk    = 1'b0;
    if (w_rxen && w_rx_tick) begin
      w_rx_deliver = (r_rx_state == S_STOP);
      w_rx_ferr    = (r_rx_state == S_STOP) && !w_rxd;
      w_rx_pchk    = (r_rx_state == S_PAR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_cnt  <= 8'h00;
      r_rx_div  <= 8'h00;
      r_rx_sr   <= 8'h00;
      r_rx_bit  <= 3'd0;
      r_rx_pbad <= 1'b0;
    end else begin
      r_rx_s1 <= uart_rxd;
      r_rx_s2 <= r_rx_s1;
      if ((r_rx_state == S_IDLE) || w_rx_tick) begin
        r_rx_cnt <= 8'h00;
        r_rx_div <= r_ubr;
      end else begin
        r_rx_cnt <= r_rx_cnt + 8'd1;
      end
      if (r_rx_state == S_IDLE) begin
        r_rx_bit  <= 3'd0;
        r_rx_pbad <= 1'b0;
      end else if ((r_rx_state == S_DATA) && w_rx_tick) begin
        r_rx_sr  <= {w_rxd, r_rx_sr[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
      if (w_rx_pchk) r_rx_pbad <= (^r_rx_sr) ^ w_rxd;
    end
  end

  // Status: error sets are written after the W1C clears so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdr <= 8'h00;
      r_rxc <= 1'b0;
      r_rov <= 1'b0;
      r_fer <= 1'b0;
      r_per <= 1'b0;
    end else begin
      if (w_wr_usr && w_wmask[3]) r_rov <= 1'b0;
      if (w_wr_usr && w_wmask[4]) r_fer <= 1'b0;
      if (w_wr_usr && w_wmask[5]) r_per <= 1'b0;
      if (w_rx_deliver && (!r_rxc || w_rd_udr)) begin
        r_rdr <= r_rx_sr;
        r_rxc <= 1'b1;
      end else if (w_rx_deliver) begin
        r_rov <= 1'b1;
      end else if (w_rd_udr) begin
        r_rxc <= 1'b0;
      end
      if (w_rx_ferr) r_fer <= 1'b1;
      if (w_rx_deliver && r_rx_pbad) r_per <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdt <= 8'h00;
      r_irq <= 2'b00;
    end else begin
      r_irq <= {w_txe & w_txeie, r_rxc & w_rxcie};
      if (io_ren && w_hit) begin
        case (w_off[1:0])
          2'd0:    r_rdt <= r_rdr;
          2'd1:    r_rdt <= {2'b00, r_per, r_fer, r_rov, w_full, w_txe, r_rxc};
          2'd2:    r_rdt <= r_ucr;
          default: r_rdt <= r_ubr;
        endcase
      end else begin
        r_rdt <= 8'h00;
      end
    end
  end

  assign io_rdt   = r_rdt;
  assign irq_req  = r_irq;
  assign uart_txd = r_txd;

endmodule

// File: tb/tb_rp_8bit_uart.sv
// Directed/randomized bench for rp_8bit_uart; serial frames are checked against a
// bit-list frame model and a byte queue for the TX FIFO.
module tb_rp_8bit_uart;

  localparam logic [5:0] A = 6'h0C;

  logic       clk, rst, io_wen, io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt, io_msk, io_rdt;
  logic [1:0] irq_req;
  logic       uart_txd, uart_rxd;
  logic       r_loop, r_drv;

  int n_cmp = 0;
  int n_bad = 0;

  assign uart_rxd = r_loop ? uart_txd : r_drv;

  rp_8bit_uart #(.ADR(A), .FAW(2)) dut (
    .clk(clk), .rst(rst), .io_wen(io_wen), .io_ren(io_ren), .io_adr(io_adr),
    .io_wdt(io_wdt), .io_msk(io_msk), .io_rdt(io_rdt), .irq_req(irq_req),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] adr, input logic [7:0] d, input logic [7:0] m);
    io_wen = 1'b1; io_adr = adr; io_wdt = d; io_msk = m;
    tick();
    io_wen = 1'b0; io_msk = 8'h00; io_wdt = 8'h00;
  endtask

  task automatic rd(input logic [5:0] adr, output logic [7:0] v);
    io_ren = 1'b1; io_adr = adr;
    tick();
    v = io_rdt;
    io_ren = 1'b0;
  endtask

  // Frame model: start 0, data LSB first, stop 1, each bit held ubr+1 cycles
  task automatic tx_check(input string tag, input int ubr, input logic [7:0] exp, output int gap);
    logic       samp [0:159];
    logic [7:0] got;
    logic       e;
    int per, n, bad, fb;
    per = ubr + 1; n = 10 * per; gap = 0; bad = 0;
    while (uart_txd !== 1'b0 && gap < 3000) begin tick(); gap++; end
    if (gap >= 3000) begin
      chk({tag, "_start_timeout"}, 32'(uart_txd), 32'(0));
      return;
    end
    for (int k = 0; k < n; k++) begin samp[k] = uart_txd; tick(); end
    for (int k = 0; k < n; k++) begin
      fb = k / per;
      e  = (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : exp[fb-1];
      if (samp[k] !== e) bad++;
    end
    for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*per + per/2];
    chk({tag, "_wave"}, 32'(bad), 32'(0));
    chk({tag, "_byte"}, 32'(got), 32'(exp));
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stopv, input int ubr);
    for (int fb = 0; fb < 10; fb++) begin
      r_drv = (fb == 0) ? 1'b0 : (fb == 9) ? stopv : b[fb-1];
      repeat (ubr + 1) tick();
    end
    r_drv = 1'b1;
  endtask

  task automatic wait_irq0(input string tag, input int bound);
    int t;
    t = 0;
    while (irq_req[0] !== 1'b1 && t < bound) begin tick(); t++; end
    chk(tag, 32'(irq_req[0]), 32'(1));
  endtask

  initial begin
    logic [7:0] rv, a, b, c;
    logic [7:0] q [$];
    int g, ubr, lows;

    rst = 1'b1; io_wen = 1'b0; io_ren = 1'b0; io_adr = 6'h00;
    io_wdt = 8'h00; io_msk = 8'h00; r_loop = 1'b0; r_drv = 1'b1;
    repeat (3) tick();
    chk("rst_rdt", 32'(io_rdt), 32'(0));
    chk("rst_irq", 32'(irq_req), 32'(0));
    chk("rst_txd", 32'(uart_txd), 32'(1));
    rst = 1'b0;
    tick();
    rd(A + 6'd1, rv); chk("rst_usr", 32'(rv), 32'h02);
    rd(A + 6'd2, rv); chk("rst_ucr", 32'(rv), 32'h00);
    rd(A + 6'd3, rv); chk("rst_ubr", 32'(rv), 32'h00);

    wr(A + 6'd2, 8'hFF, 8'h01);
    rd(A + 6'd2, rv); chk("masked_ucr", 32'(rv), 32'h01);
    wr(A + 6'd3, 8'h03, 8'hFF);
    rd(A + 6'd3, rv); chk("ubr_rw", 32'(rv), 32'h03);
    rd(6'h10, rv);    chk("out_of_range_rd", 32'(rv), 32'h00);

    // single byte, then TX-empty interrupt
    wr(A, 8'hA5, 8'hFF);
    tx_check("tx_a5", 3, 8'hA5, g);
    rd(A + 6'd1, rv); chk("tx_a5_txe", 32'(rv), 32'h02);
    wr(A + 6'd2, 8'h09, 8'hFF);
    tick(); tick();
    chk("txe_irq_on", 32'(irq_req), 32'h2);
    wr(A + 6'd2, 8'h01, 8'hFF);
    tick(); tick();
    chk("txe_irq_off", 32'(irq_req), 32'h0);

    for (int i = 0; i < 3; i++) begin
      ubr = int'($urandom_range(1, 6));
      b = 8'($urandom);
      wr(A + 6'd3, 8'(ubr), 8'hFF);
      wr(A, b, 8'hFF);
      tx_check($sformatf("tx_rand%0d", i), ubr, b, g);
    end

    // FIFO fill with TX disabled; the fifth write must be dropped
    wr(A + 6'd3, 8'h03, 8'hFF);
    wr(A + 6'd2, 8'h00, 8'hFF);
    q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      wr(A, b, 8'hFF);
      if (q.size() < 4) q.push_back(b);
      if (i == 2) begin rd(A + 6'd1, rv); chk("fifo_not_full", 32'(rv), 32'h00); end
      if (i == 3) begin rd(A + 6'd1, rv); chk("fifo_full", 32'(rv), 32'h04); end
    end
    wr(A + 6'd2, 8'h01, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tx_check($sformatf("fifo_tx%0d", i), 3, q[i], g);
      if (i > 0) chk($sformatf("fifo_gap%0d", i), 32'(g), 32'(0));
    end
    lows = 0;
    for (int i = 0; i < 50; i++) begin if (uart_txd !== 1'b1) lows++; tick(); end
    chk("fifo_no_fifth", 32'(lows), 32'(0));
    rd(A + 6'd1, rv); chk("fifo_drained", 32'(rv), 32'h02);

    // loopback receive
    r_loop = 1'b1;
    wr(A + 6'd2, 8'h07, 8'hFF);
    wr(A, 8'h3C, 8'hFF);
    wait_irq0("lb_irq", 400);
    rd(A + 6'd1, rv); chk("lb_rxc", 32'(rv[0]), 32'(1));
    rd(A, rv);        chk("lb_data", 32'(rv), 32'h3C);
    tick();
    chk("lb_irq_clr", 32'(irq_req[0]), 32'(0));
    rd(A + 6'd1, rv); chk("lb_rxc_clr", 32'(rv[0]), 32'(0));
    repeat (12) tick();

    for (int i = 0; i < 3; i++) begin
      ubr = int'($urandom_range(3, 7));
      b = 8'($urandom);
      wr(A + 6'd3, 8'(ubr), 8'hFF);
      wr(A, b, 8'hFF);
      wait_irq0($sformatf("lb_rand_irq%0d", i), 600);
      rd(A, rv); chk($sformatf("lb_rand_data%0d", i), 32'(rv), 32'(b));
      repeat (3 * (ubr + 1)) tick();
    end

    // overrun: second byte arrives while RXC is still set
    wr(A + 6'd3, 8'h03, 8'hFF);
    a = 8'($urandom);
    b = 8'($urandom);
    wr(A, a, 8'hFF);
    wait_irq0("ovr_irq", 400);
    wr(A, b, 8'hFF);
    tx_check("ovr_tx_b", 3, b, g);
    repeat (10) tick();
    rd(A + 6'd1, rv); chk("ovr_usr", 32'(rv), 32'h0B);
    rd(A, rv);        chk("ovr_keep_first", 32'(rv), 32'(a));
    rd(A + 6'd1, rv); chk("ovr_sticky", 32'(rv), 32'h0A);

    // frame error: stop bit driven low, byte still delivered
    r_loop = 1'b0;
    c = 8'($urandom);
    send_serial(c, 1'b0, 3);
    repeat (10) tick();
    rd(A + 6'd1, rv); chk("fer_usr", 32'(rv), 32'h1B);
    wr(A + 6'd1, 8'h18, 8'hFF);
    rd(A + 6'd1, rv); chk("w1c_clear", 32'(rv), 32'h03);
    rd(A, rv);        chk("fer_data", 32'(rv), 32'(c));
    rd(A + 6'd1, rv); chk("fer_after_rd", 32'(rv), 32'h02);

    // one-cycle glitch must not start a reception
    wr(A + 6'd3, 8'h07, 8'hFF);
    r_drv = 1'b0;
    tick();
    r_drv = 1'b1;
    repeat (30) tick();
    rd(A + 6'd1, rv); chk("glitch_usr", 32'(rv), 32'h02);
    chk("glitch_irq", 32'(irq_req), 32'h0);
    c = 8'($urandom);
    send_serial(c, 1'b1, 7);
    repeat (12) tick();
    rd(A, rv);        chk("post_glitch_data", 32'(rv), 32'(c));
    rd(A + 6'd1, rv); chk("post_glitch_usr", 32'(rv), 32'h02);

    // reset in the middle of a TX frame
    wr(A + 6'd3, 8'h03, 8'hFF);
    wr(A, 8'($urandom), 8'hFF);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    chk("rstm_txd", 32'(uart_txd), 32'(1));
    chk("rstm_irq", 32'(irq_req), 32'h0);
    chk("rstm_rdt", 32'(io_rdt), 32'h00);
    rst = 1'b0;
    rd(A + 6'd1, rv); chk("rstm_usr", 32'(rv), 32'h02);
    rd(A + 6'd2, rv); chk("rstm_ucr", 32'(rv), 32'h00);
    rd(A + 6'd3, rv); chk("rstm_ubr", 32'(rv), 32'h00);
    lows = 0;
    for (int i = 0; i < 40; i++) begin if (uart_txd !== 1'b1) lows++; tick(); end
    chk("rstm_idle_line", 32'(lows), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
